argon_stack_unit: RTL and testbench

- Bus responder that implements the hardware stack unit (unit ID 4'h4) on the Argon v1.5 shared unit bus.
- The bus controller initiates requests tagged with a unit ID. This block decodes requests addressed to it, executes push/pop/peek/count/clear on a LIFO of 16-bit words, and returns data plus a one-cycle acknowledge.
- All response outputs are zero when not acknowledging, so responses from several units can be OR-combined by the controller.

---
 rtl/argon_stack_unit.sv | 134 +++++++++++++
 tb/tb_argon_stack_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/argon_stack_unit.sv
// argon_stack_unit: LIFO stack responder for the Argon shared unit bus.
// Decodes requests tagged with UNIT_ID, executes push/pop/peek/count/clear
// and returns a one-cycle acknowledge. Response outputs are zero whenever
// ack is low so several units can be OR-combined by the bus controller.
module argon_stack_unit #(
  parameter int          WIDTH   = 16,
  parameter int          DEPTH   = 16,
  parameter logic [3:0]  UNIT_ID = 4'h4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_bus_valid,
  input  logic [3:0]                i_bus_id,
  input  logic [2:0]                i_bus_op,
  input  logic [WIDTH-1:0]          i_bus_data,
  output logic                      o_bus_ack,
  output logic [WIDTH-1:0]          o_bus_data,
  output logic                      o_bus_err,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP,
    S_HOLD
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_PEEK  = 3'd3,
    OP_COUNT = 3'd4,
    OP_CLEAR = 3'd5
  } op_t;

  state_t             state;
  logic [AW:0]        sp;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   resp_data_r;
  logic               err_r;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               accept;
  logic               full;
  logic               empty;
  logic [AW-1:0]      rd_idx;
  logic [WIDTH-1:0]   count_ext;

  assign full    = (sp == (AW+1)'(DEPTH));
  assign empty   = (sp == '0);
  assign o_full  = full;
  assign o_empty = empty;
  assign o_count = sp;
  assign accept  = (state == S_IDLE) && i_bus_valid && (i_bus_id == UNIT_ID);
  // Low bits of sp-1; at sp==DEPTH the truncated subtraction yields DEPTH-1.
  assign rd_idx  = sp[AW-1:0] - 1'b1;

  // Zero-extended entry count used as COUNT response data
  always_comb begin
    count_ext        = '0;
    count_ext[AW:0]  = sp;
  end

  // Stack storage: PUSH writes on the accept edge; contents are not reset
  always_ff @(posedge clk) begin
    if (!reset && accept && (i_bus_op == OP_PUSH) && !full) begin
      mem[sp[AW-1:0]] <= i_bus_data;
    end
  end

  // Request FSM: accept, optional memory read, one-cycle response, wait for valid low
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sp          <= '0;
      op_r        <= OP_NOP;
      resp_data_r <= '0;
      err_r       <= 1'b0;
      o_bus_ack   <= 1'b0;
      o_bus_data  <= '0;
      o_bus_err   <= 1'b0;
    end else begin
      o_bus_ack  <= 1'b0;
      o_bus_data <= '0;
      o_bus_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_r        <= i_bus_op;
            resp_data_r <= '0;
            err_r       <= 1'b0;
            state       <= S_RESP;
            case (i_bus_op)
              OP_PUSH: begin
                if (full) err_r <= 1'b1;
                else      sp    <= sp + 1'b1;
              end
              OP_POP, OP_PEEK: begin
                if (empty) err_r <= 1'b1;
                else       state <= S_EXEC;
              end
              OP_COUNT: resp_data_r <= count_ext;
              OP_CLEAR: sp          <= '0;
              OP_NOP:   ;
              default:  err_r       <= 1'b1;
            endcase
          end
        end
        S_EXEC: begin
          resp_data_r <= mem[rd_idx];
          if (op_r == OP_POP) sp <= sp - 1'b1;
          state <= S_RESP;
        end
        S_RESP: begin
          o_bus_ack  <= 1'b1;
          o_bus_data <= resp_data_r;
          o_bus_err  <= err_r;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          if (!i_bus_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argon_stack_unit.sv
// Testbench for argon_stack_unit: directed vector table, multi-cycle corner
// sequences, and random operations checked against a queue-based stack model.
module tb_argon_stack_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_bus_valid;
  logic [3:0]  i_bus_id;
  logic [2:0]  i_bus_op;
  logic [15:0] i_bus_data;
  logic        o_bus_ack;
  logic [15:0] o_bus_data;
  logic        o_bus_err;
  logic        o_full;
  logic        o_empty;
  logic [4:0]  o_count;

  int total = 0;
  int bad   = 0;

  argon_stack_unit #(.WIDTH(16), .DEPTH(16), .UNIT_ID(4'h4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_bus_valid(i_bus_valid),
    .i_bus_id   (i_bus_id),
    .i_bus_op   (i_bus_op),
    .i_bus_data (i_bus_data),
    .o_bus_ack  (o_bus_ack),
    .o_bus_data (o_bus_data),
    .o_bus_err  (o_bus_err),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Issue one request, wait (bounded) for ack, compare everything against expectations
  task automatic run_req(input string nm, input logic [2:0] op, input logic [3:0] id,
                         input logic [15:0] d, input logic exp_err,
                         input logic [15:0] exp_data, input int exp_lat, input int exp_cnt);
    int lat;
    lat = -1;
    i_bus_valid = 1'b1;
    i_bus_id    = id;
    i_bus_op    = op;
    i_bus_data  = d;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (o_bus_ack) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      check({nm, "_ack_timeout"}, 0, 1);
      i_bus_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      return;
    end
    check({nm, "_lat"},   lat, exp_lat);
    check({nm, "_err"},   o_bus_err, exp_err);
    check({nm, "_data"},  o_bus_data, exp_data);
    check({nm, "_count"}, o_count, exp_cnt);
    check({nm, "_empty"}, o_empty, exp_cnt == 0);
    check({nm, "_full"},  o_full, exp_cnt == 16);
    i_bus_valid = 1'b0;
    @(posedge clk); #1;
    check({nm, "_ack_one_cycle"}, o_bus_ack, 0);
    check({nm, "_idle_data"}, {o_bus_err, o_bus_data}, 0);
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [15:0] d;
    logic        err;
    logic [15:0] rd;
    int          lat;
    int          cnt;
  } vec_t;

  vec_t vt[13];

  logic [15:0] q[$];

  initial begin
    reset = 1'b1; i_bus_valid = 1'b0; i_bus_id = 4'h0; i_bus_op = 3'd0; i_bus_data = 16'h0;

    vt[0]  = '{"push_a5a5",  3'd1, 16'hA5A5, 1'b0, 16'h0000, 1, 1};
    vt[1]  = '{"pop_a5a5",   3'd2, 16'h0000, 1'b0, 16'hA5A5, 2, 0};
    vt[2]  = '{"pop_empty",  3'd2, 16'h0000, 1'b1, 16'h0000, 1, 0};
    vt[3]  = '{"peek_empty", 3'd3, 16'h0000, 1'b1, 16'h0000, 1, 0};
    vt[4]  = '{"push_1234",  3'd1, 16'h1234, 1'b0, 16'h0000, 1, 1};
    vt[5]  = '{"peek1",      3'd3, 16'h0000, 1'b0, 16'h1234, 2, 1};
    vt[6]  = '{"peek2",      3'd3, 16'h0000, 1'b0, 16'h1234, 2, 1};
    vt[7]  = '{"count1",     3'd4, 16'h0000, 1'b0, 16'h0001, 1, 1};
    vt[8]  = '{"clear",      3'd5, 16'h0000, 1'b0, 16'h0000, 1, 0};
    vt[9]  = '{"count0",     3'd4, 16'h0000, 1'b0, 16'h0000, 1, 0};
    vt[10] = '{"op7",        3'd7, 16'h5555, 1'b1, 16'h0000, 1, 0};
    vt[11] = '{"op6",        3'd6, 16'h5555, 1'b1, 16'h0000, 1, 0};
    vt[12] = '{"nop",        3'd0, 16'h5555, 1'b0, 16'h0000, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   o_bus_ack, 0);
    check("rst_data",  o_bus_data, 0);
    check("rst_err",   o_bus_err, 0);
    check("rst_count", o_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full",  o_full, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run_req(vt[i].nm, vt[i].op, 4'h4, vt[i].d, vt[i].err, vt[i].rd, vt[i].lat, vt[i].cnt);

    // Fill to capacity, overflow attempt, then drain in LIFO order
    for (int i = 1; i <= 16; i++)
      run_req("fill_push", 3'd1, 4'h4, 16'(i), 1'b0, 16'h0000, 1, i);
    run_req("push_full", 3'd1, 4'h4, 16'hFFFF, 1'b1, 16'h0000, 1, 16);
    for (int i = 16; i >= 1; i--)
      run_req("drain_pop", 3'd2, 4'h4, 16'h0000, 1'b0, 16'(i), 2, i - 1);

    // Foreign unit ID held for 5 cycles: must be ignored
    i_bus_valid = 1'b1; i_bus_id = 4'h1; i_bus_op = 3'd1; i_bus_data = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("foreign_no_ack", o_bus_ack, 0);
    end
    i_bus_valid = 1'b0;
    @(posedge clk); #1;
    check("foreign_count", o_count, 0);

    // Valid held high after ack: exactly one push, no second ack
    begin
      int lat;
      lat = -1;
      i_bus_valid = 1'b1; i_bus_id = 4'h4; i_bus_op = 3'd1; i_bus_data = 16'hBEEF;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (o_bus_ack) begin lat = k; break; end
      end
      check("hold_lat", lat, 1);
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        check("hold_no_reack", o_bus_ack, 0);
        check("hold_count", o_count, 1);
      end
      i_bus_valid = 1'b0;
      @(posedge clk); #1;
    end
    run_req("hold_peek", 3'd3, 4'h4, 16'h0000, 1'b0, 16'hBEEF, 2, 1);
    run_req("hold_clear", 3'd5, 4'h4, 16'h0000, 1'b0, 16'h0000, 1, 0);

    // Reset during EXEC of a POP with three entries
    for (int i = 0; i < 3; i++)
      run_req("pre_rst_push", 3'd1, 4'h4, 16'h3000 + 16'(i), 1'b0, 16'h0000, 1, i + 1);
    i_bus_valid = 1'b1; i_bus_id = 4'h4; i_bus_op = 3'd2;
    @(posedge clk); #1;
    reset = 1'b1; i_bus_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_ack",   o_bus_ack, 0);
    check("midrst_count", o_count, 0);
    check("midrst_empty", o_empty, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_late_ack", o_bus_ack, 0);
    end
    run_req("post_rst_push", 3'd1, 4'h4, 16'h7777, 1'b0, 16'h0000, 1, 1);
    run_req("post_rst_pop",  3'd2, 4'h4, 16'h0000, 1'b0, 16'h7777, 2, 0);

    // Random operations against a queue model of the stack
    q = {};
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [2:0]  op;
      logic [15:0] d;
      logic        e;
      logic [15:0] rd;
      int          lat;
      r  = int'($urandom_range(0, 11));
      op = (r >= 8) ? 3'd1 : 3'(r);
      d  = 16'($urandom);
      e  = 1'b0; rd = 16'h0000; lat = 1;
      case (op)
        3'd1: if (q.size() == 16) e = 1'b1; else q.push_back(d);
        3'd2: if (q.size() == 0) e = 1'b1; else begin rd = q.pop_back(); lat = 2; end
        3'd3: if (q.size() == 0) e = 1'b1; else begin rd = q[$]; lat = 2; end
        3'd4: rd = 16'(q.size());
        3'd5: q = {};
        3'd0: ;
        default: e = 1'b1;
      endcase
      run_req("rand", op, 4'h4, d, e, rd, lat, q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
